// File: rtl/icu_pkg.sv
// icu_pkg: shared state encoding and injected opcodes for the vectored interrupt unit
package icu_pkg;
    typedef enum logic [2:0] {IDLE, STALL, PUSH_CCR, PUSH_PCL, PUSH_PCH, VECTOR} state_e;
    localparam logic [15:0] NOP_OP      = 16'h0000;
    localparam logic [15:0] PUSH_CCR_OP = 16'h600A;
    localparam logic [15:0] PUSH_PCL_OP = 16'h6008;
    localparam logic [15:0] PUSH_PCH_OP = 16'h6009;
endpackage

// File: rtl/icu_prio_enc.sv
// icu_prio_enc: fixed-priority encoder, lowest set index wins
module icu_prio_enc #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  eligible,
    output logic          valid,
    output logic [IW-1:0] idx
);
    assign valid = |eligible;
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (eligible[i]) idx = IW'(i);
    end
endmodule

// File: rtl/icu_vectored.sv
// icu_vectored: latches irq edges, arbitrates, and injects NOP/PUSH CCR/PCL/PCH before vectoring the PC
module icu_vectored
    import icu_pkg::*;
#(
    parameter int NUM_IRQ       = 4,
    parameter int PC_W          = 32,
    parameter int INSTR_W       = 16,
    parameter int STALL_CYCLES  = 1,
    parameter int VECTOR_BASE   = 0,
    parameter int VECTOR_STRIDE = 2,
    localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               rti_done,
    output logic               pc_stop,
    output logic               inject_valid,
    output logic [INSTR_W-1:0] instruction,
    output logic               pc_change,
    output logic [PC_W-1:0]    pc_value,
    output logic [NUM_IRQ-1:0] ack,
    output logic               busy,
    output logic               in_service,
    output logic [IW-1:0]      active_id
);
    localparam int CW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      id_q, id_d;
    logic [NUM_IRQ-1:0] irq_q, pending_q, pending_d, clr;
    logic               in_service_q, in_service_d, win_valid;
    logic [IW-1:0]      win_idx;

    icu_prio_enc #(.N(NUM_IRQ), .IW(IW)) u_enc (
        .eligible (pending_q & ~irq_mask),
        .valid    (win_valid),
        .idx      (win_idx)
    );

    assign clr = (state_q == VECTOR) ? NUM_IRQ'(1) << id_q : '0;

    // VECTOR's set beats a same-cycle rti: that rti belongs to the previous handler
    always_comb begin
        pending_d    = (pending_q & ~clr) | (irq & ~irq_q);
        in_service_d = (state_q == VECTOR) | (in_service_q & ~rti_done);
        state_d      = state_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        case (state_q)
            IDLE: if (enable && win_valid && !in_service_q) begin
                id_d    = win_idx;
                cnt_d   = CW'(STALL_CYCLES - 1);
                state_d = STALL;
            end
            STALL: begin
                state_d = (cnt_q == '0) ? PUSH_CCR : STALL;
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
            end
            PUSH_CCR: state_d = PUSH_PCL;
            PUSH_PCL: state_d = PUSH_PCH;
            PUSH_PCH: state_d = VECTOR;
            default:  state_d = IDLE;
        endcase
        if (!enable) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            id_q         <= '0;
            irq_q        <= '0;
            pending_q    <= '0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            irq_q        <= irq;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
        end
    end

    assign busy         = state_q != IDLE;
    assign pc_stop      = busy;
    assign inject_valid = busy;
    assign instruction  = INSTR_W'((state_q == PUSH_CCR) ? PUSH_CCR_OP :
                                   (state_q == PUSH_PCL) ? PUSH_PCL_OP :
                                   (state_q == PUSH_PCH) ? PUSH_PCH_OP : NOP_OP);
    assign pc_change    = state_q == VECTOR;
    assign pc_value     = pc_change ? PC_W'(VECTOR_BASE) + PC_W'(VECTOR_STRIDE) * PC_W'(id_q) : '0;
    assign ack          = clr;
    assign in_service   = in_service_q;
    assign active_id    = id_q;
endmodule

// File: tb/tb_icu_vectored.sv
// tb_icu_vectored: directed scenarios for icu_vectored with hand-computed expectations
module tb_icu_vectored;
    logic        clk = 1'b0;
    logic        reset, enable, rti_done;
    logic [3:0]  irq, irq_mask, irq3;
    logic        pc_stop, inject_valid, pc_change, busy, in_service;
    logic [15:0] instruction;
    logic [31:0] pc_value;
    logic [3:0]  ack;
    logic [1:0]  active_id;
    logic        pc_stop3, inject_valid3, pc_change3, busy3, in_service3;
    logic [15:0] instruction3;
    logic [31:0] pc_value3;
    logic [3:0]  ack3;
    logic [1:0]  active_id3;
    int          ncmp = 0, nerr = 0;

    always #5 clk = ~clk;

    icu_vectored dut (
        .clk(clk), .reset(reset), .enable(enable), .irq(irq), .irq_mask(irq_mask),
        .rti_done(rti_done), .pc_stop(pc_stop), .inject_valid(inject_valid),
        .instruction(instruction), .pc_change(pc_change), .pc_value(pc_value),
        .ack(ack), .busy(busy), .in_service(in_service), .active_id(active_id)
    );

    icu_vectored #(.STALL_CYCLES(3), .VECTOR_BASE(16'h100)) dut3 (
        .clk(clk), .reset(reset), .enable(enable), .irq(irq3), .irq_mask(irq_mask),
        .rti_done(rti_done), .pc_stop(pc_stop3), .inject_valid(inject_valid3),
        .instruction(instruction3), .pc_change(pc_change3), .pc_value(pc_value3),
        .ack(ack3), .busy(busy3), .in_service(in_service3), .active_id(active_id3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_ins(input int i, input int sc);
        return (i == sc) ? 16'h600A : (i == sc + 1) ? 16'h6008 : (i == sc + 2) ? 16'h6009 : 16'h0000;
    endfunction

    task automatic rti_pulse();
        rti_done = 1'b1;
        tick();
        rti_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; rti_done = 1'b0; irq = '0; irq_mask = '0; irq3 = '0;
        tick(); tick();
        reset = 1'b0;
        ncmp++;
        if ({pc_stop, inject_valid, pc_change, busy, in_service} !== 5'b0 || instruction !== 16'h0000
            || pc_value !== 32'd0 || ack !== 4'b0 || active_id !== 2'd0) begin
            nerr++;
            $display("FAIL reset: stop/inj/chg/busy/insvc=%b instr=%h pcv=%h ack=%b id=%0d expected all zero",
                     {pc_stop, inject_valid, pc_change, busy, in_service}, instruction, pc_value, ack, active_id);
        end
    endtask

    task automatic test_single();
        irq = 4'b0100;
        tick();
        ncmp++;
        if (pc_stop !== 1'b0) begin nerr++; $display("FAIL single_pending: pc_stop=%b expected 0", pc_stop); end
        tick();
        for (int i = 0; i < 5; i++) begin
            ncmp++;
            if (pc_stop !== 1'b1 || inject_valid !== 1'b1 || instruction !== exp_ins(i, 1)) begin
                nerr++;
                $display("FAIL single_seq step %0d: stop=%b inj=%b instr=%h expected 1/1/%h", i, pc_stop, inject_valid, instruction, exp_ins(i, 1));
            end
            ncmp++;
            if (pc_change !== (i == 4) || pc_value !== ((i == 4) ? 32'd4 : 32'd0) || ack !== ((i == 4) ? 4'b0100 : 4'b0)) begin
                nerr++;
                $display("FAIL single_vec step %0d: chg=%b pcv=%h ack=%b", i, pc_change, pc_value, ack);
            end
            tick();
        end
        ncmp++;
        if (busy !== 1'b0 || pc_stop !== 1'b0 || in_service !== 1'b1 || active_id !== 2'd2) begin
            nerr++;
            $display("FAIL single_after: busy=%b stop=%b insvc=%b id=%0d expected 0/0/1/2", busy, pc_stop, in_service, active_id);
        end
        irq = '0;
        rti_pulse();
        ncmp++;
        if (in_service !== 1'b0) begin nerr++; $display("FAIL single_rti: in_service=%b expected 0", in_service); end
    endtask

    task automatic test_priority();
        int bad;
        irq = 4'b1010;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            ncmp++;
            if (pc_stop !== 1'b1 || instruction !== exp_ins(i, 1) || pc_value !== ((i == 4) ? 32'd2 : 32'd0)
                || ack !== ((i == 4) ? 4'b0010 : 4'b0)) begin
                nerr++;
                $display("FAIL prio_first step %0d: stop=%b instr=%h pcv=%h ack=%b", i, pc_stop, instruction, pc_value, ack);
            end
            tick();
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (pc_stop !== 1'b0) bad++;
            tick();
        end
        ncmp++;
        if (bad != 0) begin nerr++; $display("FAIL prio_no_nest: pc_stop high %0d cycles expected 0", bad); end
        rti_pulse();
        tick();
        ncmp++;
        if (active_id !== 2'd3) begin nerr++; $display("FAIL prio_second_id: active_id=%0d expected 3", active_id); end
        for (int i = 0; i < 5; i++) begin
            ncmp++;
            if (pc_stop !== 1'b1 || instruction !== exp_ins(i, 1) || pc_value !== ((i == 4) ? 32'd6 : 32'd0)
                || ack !== ((i == 4) ? 4'b1000 : 4'b0)) begin
                nerr++;
                $display("FAIL prio_second step %0d: stop=%b instr=%h pcv=%h ack=%b", i, pc_stop, instruction, pc_value, ack);
            end
            tick();
        end
        irq = '0;
        rti_pulse();
    endtask

    task automatic test_mask();
        int bad;
        irq_mask = 4'b0001;
        irq = 4'b0001;
        tick();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (pc_stop !== 1'b0) bad++;
            tick();
        end
        ncmp++;
        if (bad != 0) begin nerr++; $display("FAIL mask_hold: pc_stop high %0d cycles expected 0", bad); end
        irq_mask = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            ncmp++;
            if (pc_stop !== 1'b1 || instruction !== exp_ins(i, 1) || pc_value !== 32'd0
                || ack !== ((i == 4) ? 4'b0001 : 4'b0) || pc_change !== (i == 4)) begin
                nerr++;
                $display("FAIL mask_release step %0d: stop=%b instr=%h pcv=%h ack=%b chg=%b", i, pc_stop, instruction, pc_value, ack, pc_change);
            end
            tick();
        end
        irq = '0;
        rti_pulse();
    endtask

    task automatic test_abort();
        irq = 4'b0100;
        tick(); tick(); tick(); tick();
        ncmp++;
        if (instruction !== 16'h6008) begin nerr++; $display("FAIL abort_pcl: instr=%h expected 6008", instruction); end
        enable = 1'b0;
        tick();
        ncmp++;
        if ({pc_stop, inject_valid, busy, pc_change} !== 4'b0 || ack !== 4'b0 || instruction !== 16'h0000) begin
            nerr++;
            $display("FAIL abort_drop: stop/inj/busy/chg=%b ack=%b instr=%h expected zero", {pc_stop, inject_valid, busy, pc_change}, ack, instruction);
        end
        tick();
        enable = 1'b1;
        tick();
        ncmp++;
        if (active_id !== 2'd2 || pc_stop !== 1'b1) begin nerr++; $display("FAIL abort_retry: id=%0d stop=%b expected 2/1", active_id, pc_stop); end
        for (int i = 0; i < 5; i++) begin
            ncmp++;
            if (pc_stop !== 1'b1 || instruction !== exp_ins(i, 1) || pc_value !== ((i == 4) ? 32'd4 : 32'd0)
                || ack !== ((i == 4) ? 4'b0100 : 4'b0)) begin
                nerr++;
                $display("FAIL abort_seq step %0d: stop=%b instr=%h pcv=%h ack=%b", i, pc_stop, instruction, pc_value, ack);
            end
            if (i == 4) rti_done = 1'b1;
            tick();
            rti_done = 1'b0;
        end
        ncmp++;
        if (in_service !== 1'b1) begin nerr++; $display("FAIL rti_same_cycle: in_service=%b expected 1", in_service); end
        irq = '0;
        rti_pulse();
    endtask

    task automatic test_stall3();
        int high;
        irq3 = 4'b0010;
        tick(); tick();
        high = 0;
        for (int i = 0; i < 7; i++) begin
            if (pc_stop3 === 1'b1) high++;
            ncmp++;
            if (instruction3 !== exp_ins(i, 3) || pc_value3 !== ((i == 6) ? 32'h102 : 32'd0)
                || ack3 !== ((i == 6) ? 4'b0010 : 4'b0)) begin
                nerr++;
                $display("FAIL stall3 step %0d: instr=%h pcv=%h ack=%b expected %h", i, instruction3, pc_value3, ack3, exp_ins(i, 3));
            end
            tick();
        end
        ncmp++;
        if (high != 7 || pc_stop3 !== 1'b0) begin nerr++; $display("FAIL stall3_len: pc_stop high %0d then %b expected 7 then 0", high, pc_stop3); end
        irq3 = '0;
        rti_pulse();
    endtask

    task automatic test_back_to_back();
        int bad;
        irq = 4'b0001;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            ncmp++;
            if (pc_stop !== 1'b1 || instruction !== exp_ins(i, 1) || pc_value !== 32'd0 || ack !== ((i == 4) ? 4'b0001 : 4'b0)) begin
                nerr++;
                $display("FAIL b2b_first step %0d: stop=%b instr=%h pcv=%h ack=%b", i, pc_stop, instruction, pc_value, ack);
            end
            if (i == 1) irq = 4'b0101;
            tick();
        end
        rti_pulse();
        tick();
        ncmp++;
        if (active_id !== 2'd2 || pc_stop !== 1'b1) begin nerr++; $display("FAIL b2b_second_id: id=%0d stop=%b expected 2/1", active_id, pc_stop); end
        for (int i = 0; i < 5; i++) begin
            ncmp++;
            if (pc_stop !== 1'b1 || instruction !== exp_ins(i, 1) || pc_value !== ((i == 4) ? 32'd4 : 32'd0)
                || ack !== ((i == 4) ? 4'b0100 : 4'b0)) begin
                nerr++;
                $display("FAIL b2b_second step %0d: stop=%b instr=%h pcv=%h ack=%b", i, pc_stop, instruction, pc_value, ack);
            end
            tick();
        end
        rti_pulse();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (pc_stop !== 1'b0) bad++;
            tick();
        end
        ncmp++;
        if (bad != 0) begin nerr++; $display("FAIL b2b_level_once: pc_stop high %0d cycles expected 0", bad); end
        irq = '0;
        tick();
        irq = 4'b0001;
        tick(); tick();
        ncmp++;
        if (active_id !== 2'd0 || pc_stop !== 1'b1) begin nerr++; $display("FAIL b2b_new_edge: id=%0d stop=%b expected 0/1", active_id, pc_stop); end
        irq = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_abort();
        test_stall3();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/icu_vectored.md
Name: icu_vectored

Overview:
Multi-source vectored interrupt control unit. It sits beside the fetch stage.
- Detects rising edges on NUM_IRQ request lines and holds them as pending bits.
- Picks the highest-priority unmasked pending source.
- Stalls the PC and injects the context-save sequence: NOP stall(s), PUSH CCR, PUSH PCL, PUSH PCH.
- Redirects the PC to a per-source vector and blocks nesting until the handler signals return.

Parameters:
- NUM_IRQ, 4: number of interrupt sources; index 0 has the highest priority.
- PC_W, 32: PC / vector width.
- INSTR_W, 16: injected instruction width.
- STALL_CYCLES, 1: NOP stall cycles before the first push (≥1). They let the last in-flight CCR update write back.
- VECTOR_BASE, 0: vector address of source 0.
- VECTOR_STRIDE, 2: address spacing between consecutive source vectors.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  block enable; low aborts any sequence to IDLE.
- irq  in  NUM_IRQ  request lines, level inputs, rising-edge sensitive.
- irq_mask  in  NUM_IRQ  1 = source masked (stays pending, not serviced).
- rti_done  in  1  one-cycle pulse from the return-from-interrupt instruction; clears in-service.
- pc_stop  out  1  freeze PC / fetch.
- inject_valid  out  1  instruction output replaces the fetched word.
- instruction  out  INSTR_W  injected opcode.
- pc_change  out  1  load pc_value into PC this cycle.
- pc_value  out  PC_W  vector address; 0 when pc_change = 0.
- ack  out  NUM_IRQ  one-hot, one-cycle pulse for the serviced source.
- busy  out  1  FSM not in IDLE.
- in_service  out  1  a handler is running; no new interrupt is taken.
- active_id  out  $clog2(NUM_IRQ)  id of the source being, or last, serviced.

Behaviour:
Reset:
- State IDLE; pending, in_service, stall counter, irq_q and active_id all 0.
- All outputs 0; instruction = NOP.

Edge detect:
- irq_q is a register of irq.
- A pending bit sets on irq & ~irq_q.
- If a set and a clear hit the same bit in the same cycle, the set wins.

Arbitration:
- eligible = pending & ~irq_mask.
- The winner is the lowest set index.
- Evaluated only in IDLE with in_service = 0 and enable = 1.

FSM, with outputs decoded from the registered state:
- IDLE: all outputs 0. If eligible ≠ 0, latch active_id = winner, load the stall counter with STALL_CYCLES−1, go to STALL.
- STALL: pc_stop = 1, inject_valid = 1, instruction = NOP. When the counter reaches 0, go to PUSH_CCR; otherwise decrement.
- PUSH_CCR: pc_stop = 1, inject_valid = 1, instruction = PUSH_CCR_OP. Go to PUSH_PCL.
- PUSH_PCL: same, instruction = PUSH_PCL_OP. Go to PUSH_PCH.
- PUSH_PCH: same, instruction = PUSH_PCH_OP. Go to VECTOR.
- VECTOR:
  - Outputs: pc_stop = 1, inject_valid = 1, instruction = NOP, pc_change = 1, pc_value = VECTOR_BASE + active_id*VECTOR_STRIDE (truncated to PC_W), ack[active_id] = 1.
  - Effects: clear pending[active_id], set in_service. Go to IDLE.

Latency and duration:
- An irq edge sampled at edge k gives pending at k+1 and STALL at k+2.
- pc_stop stays high for exactly STALL_CYCLES + 4 consecutive cycles.

in_service:
- rti_done clears it in any state.
- If rti_done arrives in the same cycle VECTOR sets it, the set wins, because that rti belongs to an earlier handler.

Masking and edges during a sequence:
- A mask change mid-sequence does not abort the sequence.
- New edges arriving mid-sequence are captured in pending.
- An edge on the active source before VECTOR merges into the same service.

enable = 0:
- State is forced to IDLE and outputs drop the next cycle.
- The pending bit of the aborted source is kept, since it is cleared only in VECTOR; the source is retried when enable returns.
- Edge detection keeps running.

Reset mid-sequence: same as reset. Pending is lost.

Decomposition:
Package icu_pkg holds:
- state enum: IDLE, STALL, PUSH_CCR, PUSH_PCL, PUSH_PCH, VECTOR.
- opcode constants: NOP_OP = 16'h0000, PUSH_CCR_OP = 16'h600A, PUSH_PCL_OP = 16'h6008, PUSH_PCH_OP = 16'h6009.

Sub-module icu_prio_enc (parametrised fixed-priority encoder): input eligible, outputs valid and idx.

Test Plan:
1. Single irq: reset, then pulse irq[2] with mask 0 and defaults → pending at k+1, pc_stop high for 5 cycles from k+2. Instructions in order: 0000, 600A, 6008, 6009, 0000. In the 5th cycle: pc_change = 1, pc_value = 4, ack = 4'b0100. busy then low.
2. Priority and no nesting: irq[3] and irq[1] rise in the same cycle → source 1 serviced with pc_value = 2. Source 3 stays pending with no second sequence until rti_done. After rti_done, source 3 is serviced with pc_value = 6.
3. Masking: irq[0] rises with irq_mask[0] = 1 → no pc_stop for 20 cycles. Clear the mask → sequence starts 1 cycle later with pc_value = 0.
4. Abort: enable low during PUSH_PCL → outputs 0 next cycle and no ack. Re-enable → full sequence for the same id.
5. STALL_CYCLES = 3 instance, VECTOR_BASE = 16'h100: irq[1] → three NOP cycles before 600A, pc_stop high 7 cycles, pc_value = 32'h102.
6. Level held high through two services → exactly one service per rising edge. A second edge mid-sequence on another source is serviced after rti_done.
